sram_audio_ctrl: RTL and testbench

Sequencer for the audio SRAM wrapper: accepts record/play/stop commands and per-sample strobes from the codec side, and generates the `addr`, `read`, `write`, `play` and `record` controls that the wrapper turns into chip enables. It owns the sample address counter, the recorded length and the end-of-memory handling. It sits between the codec interface and the SRAM wrapper in the final design.

---
 rtl/sram_audio_pkg.sv | 25 ++
 rtl/sram_access_timer.sv | 38 +++
 rtl/sram_audio_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sram_audio_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_audio_pkg.sv
// Shared types and default sizing for the audio SRAM sequencer.
// The state helpers keep the mode-level decode in one place.
package sram_audio_pkg;

   localparam int ADDR_W_DEF   = 18;
   localparam int DATA_W_DEF   = 16;
   localparam int WAIT_CYC_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      REC_WAIT,
      REC_WR,
      PLAY_WAIT,
      PLAY_RD
   } state_t;

   function automatic logic is_rec(input state_t s);
      return (s == REC_WAIT) || (s == REC_WR);
   endfunction

   function automatic logic is_play(input state_t s);
      return (s == PLAY_WAIT) || (s == PLAY_RD);
   endfunction

endpackage

// File: rtl/sram_access_timer.sv
// Access-length down-counter shared by the write and read phases.
// done is high on the last cycle of a WAIT_CYC-long access.
module sram_access_timer
   import sram_audio_pkg::*;
#(
   parameter int WAIT_CYC = WAIT_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic done
);

   localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   logic [CNT_W-1:0] cnt;
   logic             active;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= CNT_W'(WAIT_CYC - 1);
      end else if (active) begin
         if (cnt == '0) begin
            active <= 1'b0;
         end else begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign done = active && (cnt == '0);

endmodule

// File: rtl/sram_audio_ctrl.sv
// Record/playback sequencer driving the audio SRAM wrapper controls.
// Every output is a flop; strobes and mode levels are decoded from the next state.
module sram_audio_ctrl
   import sram_audio_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WAIT_CYC = WAIT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_record,
   input  logic              cmd_play,
   input  logic              cmd_stop,
   input  logic              loop_en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_req,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_out_valid,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_read,
   output logic              sram_write,
   output logic              sram_play,
   output logic              sram_record,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic [ADDR_W:0]   rec_len,
   output logic              busy,
   output logic              full,
   output logic              overrun
);

   state_t              state, state_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [ADDR_W:0]     rec_len_d;
   logic [DATA_W-1:0]   wdata_d;
   logic [DATA_W-1:0]   sample_out_d;
   logic                out_valid_d;
   logic                full_d;
   logic                overrun_d;
   logic                timer_start;
   logic                timer_done;
   logic                cmd_any;
   logic                addr_last;
   logic                play_last;

   assign cmd_any   = cmd_stop | cmd_record | cmd_play;
   assign addr_last = &sram_addr;
   // rec_len is one bit wider so a completely full memory still compares correctly
   assign play_last = (({1'b0, sram_addr} + (ADDR_W+1)'(1)) == rec_len);

   sram_access_timer #(
      .WAIT_CYC (WAIT_CYC)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (timer_start),
      .abort (cmd_any),
      .done  (timer_done)
   );

   always_comb begin
      state_d      = state;
      addr_d       = sram_addr;
      rec_len_d    = rec_len;
      wdata_d      = sram_wdata;
      sample_out_d = sample_out;
      out_valid_d  = 1'b0;
      full_d       = full;
      overrun_d    = overrun;
      timer_start  = 1'b0;

      // Commands outrank everything and abandon any access in flight
      if (cmd_stop) begin
         state_d = IDLE;
      end else if (cmd_record) begin
         state_d   = REC_WAIT;
         addr_d    = '0;
         rec_len_d = '0;
         full_d    = 1'b0;
         overrun_d = 1'b0;
      end else if (cmd_play) begin
         if (rec_len == '0) begin
            state_d = IDLE;
         end else begin
            state_d = PLAY_WAIT;
            addr_d  = '0;
         end
      end else begin
         case (state)
            REC_WAIT: begin
               if (sample_valid) begin
                  wdata_d     = sample_in;
                  timer_start = 1'b1;
                  state_d     = REC_WR;
               end
            end
            REC_WR: begin
               if (sample_valid) begin
                  overrun_d = 1'b1;
               end
               if (timer_done) begin
                  rec_len_d = rec_len + (ADDR_W+1)'(1);
                  if (addr_last) begin
                     full_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     addr_d  = sram_addr + ADDR_W'(1);
                     state_d = REC_WAIT;
                  end
               end
            end
            PLAY_WAIT: begin
               if (sample_req) begin
                  timer_start = 1'b1;
                  state_d     = PLAY_RD;
               end
            end
            PLAY_RD: begin
               if (timer_done) begin
                  sample_out_d = sram_rdata;
                  out_valid_d  = 1'b1;
                  if (play_last) begin
                     addr_d  = '0;
                     state_d = loop_en ? PLAY_WAIT : IDLE;
                  end else begin
                     addr_d  = sram_addr + ADDR_W'(1);
                     state_d = PLAY_WAIT;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         sram_addr        <= '0;
         rec_len          <= '0;
         sram_wdata       <= '0;
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
         full             <= 1'b0;
         overrun          <= 1'b0;
         sram_write       <= 1'b0;
         sram_read        <= 1'b0;
         sram_record      <= 1'b0;
         sram_play        <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state            <= state_d;
         sram_addr        <= addr_d;
         rec_len          <= rec_len_d;
         sram_wdata       <= wdata_d;
         sample_out       <= sample_out_d;
         sample_out_valid <= out_valid_d;
         full             <= full_d;
         overrun          <= overrun_d;
         sram_write       <= (state_d == REC_WR);
         sram_read        <= (state_d == PLAY_RD);
         sram_record      <= is_rec(state_d);
         sram_play        <= is_play(state_d);
         busy             <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_sram_audio_ctrl.sv
// Directed bench for sram_audio_ctrl with a small SRAM model and access scoreboards.
// Uses a 4-bit address so the end-of-memory case is reachable quickly.
module tb_sram_audio_ctrl;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int WC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_record, cmd_play, cmd_stop, loop_en;
   logic          sample_valid, sample_req;
   logic [DW-1:0] sample_in;
   logic [DW-1:0] sample_out;
   logic          sample_out_valid;
   logic [AW-1:0] sram_addr;
   logic          sram_read, sram_write, sram_play, sram_record;
   logic [DW-1:0] sram_wdata, sram_rdata;
   logic [AW:0]   rec_len;
   logic          busy, full, overrun;

   int n_vec  = 0;
   int n_miss = 0;

   // Expected write: {len[23:20], addr[19:16], data[15:0]}
   logic [23:0]   exp_wr_q[$];
   logic [AW-1:0] exp_rd_q[$];
   logic [DW-1:0] exp_out_q[$];
   logic [DW-1:0] mem [16];

   always #5 clk = ~clk;

   assign sram_rdata = sram_read ? mem[sram_addr] : '0;

   sram_audio_ctrl #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .WAIT_CYC (WC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_record       (cmd_record),
      .cmd_play         (cmd_play),
      .cmd_stop         (cmd_stop),
      .loop_en          (loop_en),
      .sample_valid     (sample_valid),
      .sample_in        (sample_in),
      .sample_req       (sample_req),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .sram_addr        (sram_addr),
      .sram_read        (sram_read),
      .sram_write       (sram_write),
      .sram_play        (sram_play),
      .sram_record      (sram_record),
      .sram_wdata       (sram_wdata),
      .sram_rdata       (sram_rdata),
      .rec_len          (rec_len),
      .busy             (busy),
      .full             (full),
      .overrun          (overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic rec, input logic ply, input logic stp);
      cmd_record = rec;
      cmd_play   = ply;
      cmd_stop   = stp;
      tick();
      cmd_record = 1'b0;
      cmd_play   = 1'b0;
      cmd_stop   = 1'b0;
   endtask

   task automatic rec_sample(input logic [DW-1:0] v, input logic [AW-1:0] a);
      exp_wr_q.push_back({4'(WC), a, v});
      sample_in    = v;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check("wr_strobe_first", sram_write, 1);
      check("wr_addr_first", sram_addr, a);
      tick();
      check("wr_strobe_last", sram_write, 1);
      tick();
      check("wr_strobe_off", sram_write, 0);
      check("wr_rec_len", rec_len, 32'(a) + 1);
   endtask

   task automatic play_req(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic hold);
      exp_rd_q.push_back(a);
      exp_out_q.push_back(v);
      sample_req = 1'b1;
      tick();
      if (!hold) sample_req = 1'b0;
      check("rd_strobe_first", sram_read, 1);
      check("rd_addr", sram_addr, a);
      check("rd_valid_early", sample_out_valid, 0);
      tick();
      check("rd_strobe_last", sram_read, 1);
      tick();
      sample_req = 1'b0;
      check("rd_valid", sample_out_valid, 1);
      check("rd_sample_out", sample_out, v);
      check("rd_strobe_off", sram_read, 0);
   endtask

   // Scoreboard and SRAM model, sampled mid-cycle
   logic        mon_on = 1'b0;
   logic        wr_prev = 1'b0;
   logic        rd_prev = 1'b0;
   int          wr_run = 0;
   logic [23:0] cur_wr = '0;

   always @(negedge clk) begin
      if (mon_on) begin
         check("strobe_excl", {30'd0, sram_read & sram_write, sram_play & sram_record}, 0);
         if (sram_write) begin
            if (!wr_prev) begin
               check("wr_expected", exp_wr_q.size() != 0, 1);
               if (exp_wr_q.size() != 0) cur_wr = exp_wr_q.pop_front();
               check("sb_wr_addr", sram_addr, cur_wr[19:16]);
               check("sb_wr_data", sram_wdata, cur_wr[15:0]);
               wr_run = 1;
            end else begin
               wr_run++;
               check("sb_wr_stable", {sram_addr, sram_wdata}, cur_wr[19:0]);
            end
            mem[sram_addr] = sram_wdata;
         end else if (wr_prev) begin
            check("sb_wr_len", wr_run, cur_wr[23:20]);
         end
         if (sram_read && !rd_prev) begin
            check("rd_expected", exp_rd_q.size() != 0, 1);
            if (exp_rd_q.size() != 0) check("sb_rd_addr", sram_addr, exp_rd_q.pop_front());
         end
         if (sample_out_valid) begin
            check("out_expected", exp_out_q.size() != 0, 1);
            if (exp_out_q.size() != 0) check("sb_out", sample_out, exp_out_q.pop_front());
         end
         wr_prev = sram_write;
         rd_prev = sram_read;
      end
   end

   initial begin
      rst          = 1'b1;
      cmd_record   = 1'b0;
      cmd_play     = 1'b0;
      cmd_stop     = 1'b0;
      loop_en      = 1'b0;
      sample_valid = 1'b0;
      sample_in    = '0;
      sample_req   = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      rst    = 1'b0;
      mon_on = 1'b1;

      // Idle after reset: everything low
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_ctl", {sram_read, sram_write, sram_play, sram_record,
                            busy, full, overrun, sample_out_valid}, 0);
      end
      check("idle_addr", sram_addr, 0);
      check("idle_rec_len", rec_len, 0);
      check("idle_sample_out", sample_out, 0);
      check("idle_wdata", sram_wdata, 0);

      // Play with nothing recorded stays idle
      do_cmd(0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         check("play_empty_busy", busy, 0);
         check("play_empty_rd", sram_read, 0);
         tick();
      end

      // Record four samples, then stop
      do_cmd(1, 0, 0);
      check("rec_busy", busy, 1);
      check("rec_mode", {sram_record, sram_play}, 2'b10);
      check("rec_len_clr", rec_len, 0);
      rec_sample(16'h1111, 0);
      rec_sample(16'h2222, 1);
      rec_sample(16'h3333, 2);
      rec_sample(16'h4444, 3);
      do_cmd(0, 0, 1);
      check("stop_busy", busy, 0);
      check("stop_mode", {sram_record, sram_play}, 0);
      check("stop_rec_len", rec_len, 4);

      // Single-shot playback; fifth request finds the sequencer idle
      do_cmd(0, 1, 0);
      check("play_busy", busy, 1);
      check("play_mode", {sram_record, sram_play}, 2'b01);
      check("play_addr0", sram_addr, 0);
      play_req(0, 16'h1111, 0);
      play_req(1, 16'h2222, 0);
      play_req(2, 16'h3333, 0);
      play_req(3, 16'h4444, 0);
      check("play_end_busy", busy, 0);
      check("play_end_mode", sram_play, 0);
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("req5_no_read", sram_read, 0);
         check("req5_no_valid", sample_out_valid, 0);
         tick();
      end
      check("play_keeps_len", rec_len, 4);

      // Looping playback, request held through each access
      loop_en = 1'b1;
      do_cmd(0, 1, 0);
      play_req(0, 16'h1111, 1);
      play_req(1, 16'h2222, 1);
      play_req(2, 16'h3333, 1);
      play_req(3, 16'h4444, 1);
      play_req(0, 16'h1111, 1);
      play_req(1, 16'h2222, 1);
      check("loop_busy", busy, 1);
      do_cmd(0, 0, 1);
      check("loop_stop_busy", busy, 0);
      loop_en = 1'b0;

      // Sample offered during a write is dropped and flags overrun
      do_cmd(1, 0, 0);
      check("rerec_len", rec_len, 0);
      check("rerec_overrun", overrun, 0);
      exp_wr_q.push_back({4'(WC), 4'd0, 16'hAAAA});
      sample_in    = 16'hAAAA;
      sample_valid = 1'b1;
      tick();
      check("ovr_wr_on", sram_write, 1);
      sample_in = 16'hBBBB;
      tick();
      sample_valid = 1'b0;
      check("ovr_flag", overrun, 1);
      check("ovr_wdata_kept", sram_wdata, 16'hAAAA);
      tick();
      check("ovr_wr_off", sram_write, 0);
      check("ovr_rec_len", rec_len, 1);
      check("ovr_addr", sram_addr, 1);
      rec_sample(16'hCCCC, 1);
      check("ovr_sticky", overrun, 1);

      // Stop outranks record when pulsed together
      do_cmd(1, 0, 1);
      check("stop_rec_busy", busy, 0);
      check("stop_rec_mode", sram_record, 0);
      check("stop_rec_ovr", overrun, 1);
      check("stop_rec_len", rec_len, 2);
      do_cmd(1, 0, 0);
      check("ovr_cleared", overrun, 0);
      check("rec2_busy", busy, 1);

      // Reset in the middle of a write cuts the strobe
      exp_wr_q.push_back({4'd1, 4'd0, 16'hDDDD});
      sample_in    = 16'hDDDD;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check("rstw_wr_on", sram_write, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstw_wr_off", sram_write, 0);
      check("rstw_rec_len", rec_len, 0);
      check("rstw_busy", busy, 0);
      check("rstw_mode", sram_record, 0);

      // Fill the whole 16-word memory
      do_cmd(1, 0, 0);
      for (int i = 0; i < 15; i++) begin
         rec_sample(16'h0100 + 16'(i), 4'(i));
      end
      check("fill_not_full", full, 0);
      check("fill_busy", busy, 1);
      rec_sample(16'h010F, 4'd15);
      check("full_flag", full, 1);
      check("full_busy", busy, 0);
      check("full_mode", sram_record, 0);
      check("full_rec_len", rec_len, 16);

      // Play back the full memory once
      do_cmd(0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         play_req(4'(i), 16'h0100 + 16'(i), 0);
      end
      check("full_play_busy", busy, 0);

      repeat (2) tick();
      check("wr_q_drained", exp_wr_q.size(), 0);
      check("rd_q_drained", exp_rd_q.size(), 0);
      check("out_q_drained", exp_out_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
